sc_window_decode: RTL
=====================

SC_WINDOW_DECODE -- requirements
Module: sc_window_decode

Interface
REQ-001 Parameter BITWIDTH, 8, width of window length, window counter and ones count.
REQ-002 Parameter FBITWIDTH, 4, width of probability output; 1.0 = 2^(FBITWIDTH-1), 0.5 = 2^(FBITWIDTH-2).
REQ-003 iClk  input  1  single clock; all state updates on rising edge.
REQ-004 iRst  input  1  reset, synchronous, active-high.
REQ-005 iClr  input  1  synchronous clear of the accumulation in progress.
REQ-006 iEn  input  1  sample enable; low pauses accumulation.
REQ-007 iWindow  input  BITWIDTH  window length in samples; must equal 2^iWINLOG2.
REQ-008 iWINLOG2  input  BITWIDTH  log2 of window length; valid range 0..BITWIDTH-1.
REQ-009 iA  input  1  stochastic bitstream sample.
REQ-010 iReady  input  1  consumer accepts the held result.
REQ-011 oValid  output  1  result register holds an unconsumed result.
REQ-012 oCnt  output  BITWIDTH  ones count of the last completed window.
REQ-013 oProb  output  FBITWIDTH  decoded probability of the last completed window.
REQ-014 oOvf  output  1  sticky flag: an unconsumed result was overwritten.

Function
REQ-015 The FSM shall have states IDLE (after reset, no sample yet taken) and ACCUM; IDLE->ACCUM on first cycle with iEn=1; ACCUM never returns to IDLE except by iRst or iClr.
REQ-016 Each cycle with iEn=1, the block shall add iA to the running ones count and advance the window position by one.
REQ-017 Each cycle with iEn=0, the running count and window position shall hold; oValid/oCnt/oProb shall hold.
REQ-018 On the enabled cycle that samples the iWindow-th bit, the result register shall load oCnt = running count including that bit; oValid shall rise in the following cycle (latency 1 cycle from final sample edge).
REQ-019 Windows shall be back-to-back: the next enabled cycle after completion is sample 1 of the next window, running count restarting at 0 plus iA.
REQ-020 oProb shall equal (oCnt << (FBITWIDTH-1)) >> iWINLOG2, computed at BITWIDTH+FBITWIDTH bits, saturated to 2^(FBITWIDTH-1), registered with oCnt.
REQ-021 iWindow=0 shall be treated as window length 1.
REQ-022 oValid shall clear on a cycle with oValid=1 and iReady=1 unless a new result loads that same cycle.
REQ-023 New result load with oValid=1 and iReady=0: result shall be overwritten, oValid stays 1, oOvf set to 1.
REQ-024 New result load with oValid=1 and iReady=1: new result loaded, oValid stays 1, oOvf unchanged.
REQ-025 Priority shall be iRst > iClr > iEn.

Reset
REQ-026 iRst=1 shall force state IDLE, running count 0, window position 0, oValid=0, oCnt=0, oProb=0, oOvf=0 at the next edge, including mid-window.
REQ-027 iClr=1 shall zero running count and window position, return to IDLE, clear oOvf; oValid, oCnt, oProb shall hold.

Configuration
REQ-028 Macro SC_DELTA_EN defined: port oDelta output FBITWIDTH shall exist, two's-complement oProb minus 0.5, registered with oProb, reset to 0.
REQ-029 Macro SC_DELTA_EN undefined: oDelta port and its logic shall be absent; all other behaviour identical.

Structure
REQ-030 Shared package sc_stream_pkg shall hold the half/one probability constants as functions of FBITWIDTH and the FSM state encoding.
REQ-031 Sub-module sc_window_cnt shall implement window position counting and the last-sample strobe; top holds FSM, accumulator, result register and handshake.

Verification (BITWIDTH=8, FBITWIDTH=4, iWindow=8, iWINLOG2=3, iReady=1 unless stated)
REQ-032 8 enabled cycles iA=1 -> oValid pulses 1 cycle, oCnt=8, oProb=8, oDelta=4.
REQ-033 Alternating 1,0 for 8 cycles -> oCnt=4, oProb=4, oDelta=0.
REQ-034 Two 1s in 8 samples -> oCnt=2, oProb=2, oDelta=4'b1110 (-2).
REQ-035 iReady=0 over two full windows (8 ones, then 3 ones) -> oCnt=3, oValid=1, oOvf=1; iReady=1 one cycle -> oValid=0, oOvf stays 1.
REQ-036 iEn=0 for 3 cycles after sample 4 -> oValid rises 3 cycles later than uninterrupted; oCnt unchanged.
REQ-037 iClr after 5 samples of 1, then 8 samples of 0 -> oCnt=0, oOvf=0; iRst after 5 samples -> all outputs 0 next cycle, next result after 8 new enabled samples.

Source files
------------

// File: rtl/sc_stream_pkg.sv
// Shared constants for stochastic-stream decoders: fixed-point probability
// references and the decoder FSM encoding.
package sc_stream_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  // Probability 1.0 sits at bit FBITWIDTH-1 so it stays representable unsigned.
  function automatic int probOne(input int fbw);
    return 1 << (fbw - 1);
  endfunction

  function automatic int probHalf(input int fbw);
    return 1 << (fbw - 2);
  endfunction

endpackage

// File: rtl/sc_window_decode_if.sv
// Result handshake bundle of sc_window_decode; oDelta exists only when
// SC_DELTA_EN is defined.
interface sc_window_decode_if #(
  parameter int BITWIDTH  = 8,
  parameter int FBITWIDTH = 4
);

  logic                 iReady;
  logic                 oValid;
  logic [BITWIDTH-1:0]  oCnt;
  logic [FBITWIDTH-1:0] oProb;
  logic                 oOvf;
`ifdef SC_DELTA_EN
  logic [FBITWIDTH-1:0] oDelta;

  modport master (input iReady, output oValid, oCnt, oProb, oOvf, oDelta);
  modport slave  (output iReady, input oValid, oCnt, oProb, oOvf, oDelta);
`else
  modport master (input iReady, output oValid, oCnt, oProb, oOvf);
  modport slave  (output iReady, input oValid, oCnt, oProb, oOvf);
`endif

endinterface

// File: rtl/sc_window_cnt.sv
// Window position counter: flags the enabled sample that closes the current
// window and wraps back-to-back into the next one.
module sc_window_cnt #(
  parameter int BITWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [BITWIDTH-1:0] window_i,
  output logic                last_o
);

  logic [BITWIDTH-1:0] pos_q;
  logic [BITWIDTH-1:0] pos_d;
  logic [BITWIDTH-1:0] lastPos;

  // A zero window length behaves as length 1; >= recovers if the length shrinks mid-window.
  assign lastPos = (window_i == '0) ? '0 : window_i - BITWIDTH'(1);
  assign last_o  = en_i && !clr_i && (pos_q >= lastPos);

  always_comb begin
    pos_d = pos_q;
    if (clr_i) begin
      pos_d = '0;
    end else if (en_i) begin
      pos_d = last_o ? '0 : pos_q + BITWIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

endmodule

// File: rtl/sc_window_decode.sv
// Windowed stochastic bitstream decoder: counts ones per window and presents
// count and probability through a valid/ready result register.
// Optional SC_DELTA_EN adds oDelta = oProb - 0.5 (two's complement).
module sc_window_decode
  import sc_stream_pkg::*;
#(
  parameter int BITWIDTH  = 8,
  parameter int FBITWIDTH = 4
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iClr,
  input  logic                iEn,
  input  logic [BITWIDTH-1:0] iWindow,
  input  logic [BITWIDTH-1:0] iWINLOG2,
  input  logic                iA,
  sc_window_decode_if.master  res
);

  localparam int WIDE = BITWIDTH + FBITWIDTH;
  localparam logic [WIDE-1:0]      PROB_ONE_W = WIDE'(probOne(FBITWIDTH));
  localparam logic [FBITWIDTH-1:0] PROB_ONE   = FBITWIDTH'(probOne(FBITWIDTH));

  logic [0:0]           state_q, state_d;
  logic [BITWIDTH-1:0]  acc_q, acc_d;
  logic                 valid_q, valid_d;
  logic [BITWIDTH-1:0]  resCnt_q, resCnt_d;
  logic [FBITWIDTH-1:0] prob_q, prob_d;
  logic                 ovf_q, ovf_d;
  logic                 winLast;
  logic [BITWIDTH-1:0]  sum;
  logic [WIDE-1:0]      probWide;
  logic [FBITWIDTH-1:0] probNew;

  sc_window_cnt #(.BITWIDTH(BITWIDTH)) u_window_cnt (
    .clk      (iClk),
    .rst      (iRst),
    .clr_i    (iClr),
    .en_i     (iEn),
    .window_i (iWindow),
    .last_o   (winLast)
  );

  assign sum      = acc_q + BITWIDTH'(iA);
  assign probWide = (WIDE'(sum) << (FBITWIDTH - 1)) >> iWINLOG2;
  assign probNew  = (probWide > PROB_ONE_W) ? PROB_ONE : probWide[FBITWIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    valid_d  = valid_q;
    resCnt_d = resCnt_q;
    prob_d   = prob_q;
    ovf_d    = ovf_q;
    if (iClr) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      if (valid_q && res.iReady) begin
        valid_d = 1'b0;
      end
      if (iEn) begin
        state_d = ST_ACCUM;
        acc_d   = sum;
        // Closing sample: load the result and restart the count for the next window.
        if (winLast) begin
          acc_d    = '0;
          valid_d  = 1'b1;
          resCnt_d = sum;
          prob_d   = probNew;
          if (valid_q && !res.iReady) begin
            ovf_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      resCnt_q <= '0;
      prob_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      valid_q  <= valid_d;
      resCnt_q <= resCnt_d;
      prob_q   <= prob_d;
      ovf_q    <= ovf_d;
    end
  end

  assign res.oValid = valid_q;
  assign res.oCnt   = resCnt_q;
  assign res.oProb  = prob_q;
  assign res.oOvf   = ovf_q;

`ifdef SC_DELTA_EN
  localparam logic [FBITWIDTH-1:0] PROB_HALF = FBITWIDTH'(probHalf(FBITWIDTH));

  logic [FBITWIDTH-1:0] delta_q, delta_d;

  always_comb begin
    delta_d = delta_q;
    if (!iClr && iEn && winLast) begin
      delta_d = probNew - PROB_HALF;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      delta_q <= '0;
    end else begin
      delta_q <= delta_d;
    end
  end

  assign res.oDelta = delta_q;
`endif

endmodule
